// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver.
// Turns the 11-bit device-to-host frames into scan-code bytes and keeps the
// last two accepted bytes.
// Ports:
//   CLK, RST             system clock, asynchronous active-high reset
//   PS2_CLK, PS2_DATA    raw keyboard lines (asynchronous to CLK)
//   TECLADO_REG          last accepted scan-code byte
//   TECLADO_REG_ANTERIOR byte accepted just before TECLADO_REG
//   DATO_LISTO           one-cycle pulse for each accepted byte
//   ERROR_TRAMA          one-cycle pulse for each rejected or aborted frame
module ps2_teclado_rx #(
  parameter int unsigned FILTRO_LEN     = 8,
  parameter int unsigned TIMEOUT_CICLOS = 200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] TECLADO_REG,
  output logic [7:0] TECLADO_REG_ANTERIOR,
  output logic       DATO_LISTO,
  output logic       ERROR_TRAMA
);

  localparam int unsigned FW = $clog2(FILTRO_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, PARADA} estado_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          fclk_q, fclk_d, fclk_prev_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  estado_t       estado_q, estado_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          paridad_q, paridad_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    reg_q, reg_d, ant_q, ant_d;
  logic          listo_q, listo_d, error_q, error_d;
  logic          fe, timeout_hit;

  // State register: every flop, all reset to the idle bus level / zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      estado_q    <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      paridad_q   <= 1'b0;
      to_cnt_q    <= '0;
      reg_q       <= '0;
      ant_q       <= '0;
      listo_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      clk_s1_q    <= PS2_CLK;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= PS2_DATA;
      dat_s2_q    <= dat_s1_q;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_q;
      filt_cnt_q  <= filt_cnt_d;
      estado_q    <= estado_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      paridad_q   <= paridad_d;
      to_cnt_q    <= to_cnt_d;
      reg_q       <= reg_d;
      ant_q       <= ant_d;
      listo_q     <= listo_d;
      error_q     <= error_d;
    end
  end

  // Glitch filter: count consecutive samples that disagree with fclk; any
  // agreeing sample restarts the count, so short glitches never pass.
  always_comb begin
    fclk_d     = fclk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != fclk_q) begin
      if (filt_cnt_q == FW'(FILTRO_LEN - 1)) begin
        fclk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  assign fe = fclk_prev_q & ~fclk_q;

  // A clock fall in the same cycle takes priority over the timeout.
  assign timeout_hit = (estado_q != IDLE) && !fe &&
                       (to_cnt_q == TW'(TIMEOUT_CICLOS - 1));

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    if (fe) begin
      case (estado_q)
        IDLE:    if (!dat_s2_q) estado_d = DATOS;
        DATOS:   if (bit_cnt_q == 3'd7) estado_d = PARIDAD;
        PARIDAD: estado_d = PARADA;
        PARADA:  estado_d = IDLE;
        default: estado_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      estado_d = IDLE;
    end
  end

  // Datapath and output logic.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    paridad_d = paridad_q;
    reg_d     = reg_q;
    ant_d     = ant_q;
    listo_d   = 1'b0;
    error_d   = 1'b0;
    to_cnt_d  = (fe || estado_q == IDLE || timeout_hit) ? '0 : to_cnt_q + TW'(1);
    if (fe) begin
      case (estado_q)
        IDLE:    bit_cnt_d = '0;
        DATOS: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARIDAD: paridad_d = dat_s2_q;
        PARADA: begin
          // Odd parity over data + parity bit, and stop bit must be high.
          if (dat_s2_q && (^{shift_q, paridad_q})) begin
            ant_d   = reg_q;
            reg_d   = shift_q;
            listo_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      error_d = 1'b1;
    end
  end

  assign TECLADO_REG          = reg_q;
  assign TECLADO_REG_ANTERIOR = ant_q;
  assign DATO_LISTO           = listo_q;
  assign ERROR_TRAMA          = error_q;

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Bench for ps2_teclado_rx: directed and random PS/2 frames, a byte-history
// reference model feeding an expectation queue, and a monitor that pops and
// compares on every DATO_LISTO / ERROR_TRAMA pulse.
module tb_ps2_teclado_rx;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 1000;
  localparam int unsigned H  = 30;   // PS/2 half period in CLK cycles

  typedef struct packed {
    logic       es_error;
    logic [7:0] reg_v;
    logic [7:0] ant_v;
  } ev_t;

  logic       CLK = 1'b0, RST = 1'b1, PS2_CLK = 1'b1, PS2_DATA = 1'b1;
  logic [7:0] TECLADO_REG, TECLADO_REG_ANTERIOR;
  logic       DATO_LISTO, ERROR_TRAMA;

  ev_t        exp_q[$];
  logic [7:0] m_reg = 8'h00, m_ant = 8'h00;
  int         n_checks = 0, n_pass = 0;
  int         cyc = 0, last_fall = 0;

  ps2_teclado_rx #(.FILTRO_LEN(FL), .TIMEOUT_CICLOS(TO)) dut (
    .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .TECLADO_REG(TECLADO_REG), .TECLADO_REG_ANTERIOR(TECLADO_REG_ANTERIOR),
    .DATO_LISTO(DATO_LISTO), .ERROR_TRAMA(ERROR_TRAMA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: history of the last two good bytes.
  task automatic expect_frame(input logic [7:0] b, input bit ok);
    ev_t e;
    if (ok) begin
      e = '{es_error: 1'b0, reg_v: b, ant_v: m_reg};
      m_ant = m_reg;
      m_reg = b;
    end else begin
      e = '{es_error: 1'b1, reg_v: m_reg, ant_v: m_ant};
    end
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLK) PS2_DATA = b;
    repeat (H / 2) @(negedge CLK);
    PS2_CLK   = 1'b0;
    last_fall = cyc;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (H / 2) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    repeat (4) @(negedge CLK);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    expect_frame(b, !(bad_par || bad_stop));
    send_frame(b, bad_par, bad_stop);
  endtask

  // Monitor: every output pulse must match the head of the queue.
  always @(negedge CLK) begin
    if (!RST && (DATO_LISTO || ERROR_TRAMA)) begin
      chk("exclusive_pulses", 32'(DATO_LISTO && ERROR_TRAMA), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got listo=%0b error=%0b expected none reg=%0h",
                 DATO_LISTO, ERROR_TRAMA, TECLADO_REG);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(ERROR_TRAMA), 32'(e.es_error));
        chk("teclado_reg", 32'(TECLADO_REG), 32'(e.reg_v));
        chk("teclado_ant", 32'(TECLADO_REG_ANTERIOR), 32'(e.ant_v));
      end
    end
  end

  initial begin
    logic [7:0] b, prev;
    int r, waited;
    bit found;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_reg", 32'(TECLADO_REG), 32'h0);
    chk("rst_ant", 32'(TECLADO_REG_ANTERIOR), 32'h0);
    chk("rst_listo", 32'(DATO_LISTO), 32'h0);
    chk("rst_error", 32'(ERROR_TRAMA), 32'h0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Single frame, then make/break/make sequence
    frame(8'h75, 0, 0);
    chk("first_reg", 32'(TECLADO_REG), 32'h75);
    chk("first_ant", 32'(TECLADO_REG_ANTERIOR), 32'h00);
    frame(8'hF0, 0, 0);
    frame(8'h75, 0, 0);
    chk("break_ant", 32'(TECLADO_REG_ANTERIOR), 32'hF0);

    // Bad parity after a good byte
    frame(8'h6B, 0, 0);
    frame(8'h72, 1, 0);
    chk("parity_err_reg", 32'(TECLADO_REG), 32'h6B);

    // Short clock glitches with data low must not start a frame
    for (int g = 0; g < 3; g++) begin
      @(negedge CLK) PS2_DATA = 1'b0;
      PS2_CLK = 1'b0;
      repeat (3) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (20) @(negedge CLK);
    end
    PS2_DATA = 1'b1;
    frame(8'h74, 0, 0);

    // Timeout: start bit plus 4 data bits, then silence
    expect_frame(8'h00, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(r[0] ^ 1'b1);
    found  = 0;
    waited = 0;
    while (!found && waited < int'(TO) + 200) begin
      @(negedge CLK);
      waited++;
      if (ERROR_TRAMA) found = 1;
    end
    n_checks++;
    if (found && (cyc - last_fall) >= int'(TO + FL) && (cyc - last_fall) <= int'(TO + FL + 7))
      n_pass++;
    else
      $display("FAIL timeout_delay: got %0d cycles (seen=%0b) expected %0d..%0d",
               cyc - last_fall, found, TO + FL, TO + FL + 7);
    repeat (5) @(negedge CLK);
    frame(8'h6B, 0, 0);
    chk("after_timeout_reg", 32'(TECLADO_REG), 32'h6B);

    // Reset mid-frame after the 5th data bit; abandoned frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(logic'(8'h72 >> i));
    @(negedge CLK) RST = 1'b1;
    #1;
    chk("midrst_reg", 32'(TECLADO_REG), 32'h0);
    chk("midrst_ant", 32'(TECLADO_REG_ANTERIOR), 32'h0);
    chk("midrst_listo", 32'(DATO_LISTO), 32'h0);
    chk("midrst_error", 32'(ERROR_TRAMA), 32'h0);
    m_reg = 8'h00;
    m_ant = 8'h00;
    @(negedge CLK) RST = 1'b0;
    PS2_DATA = 1'b1;
    repeat (10) @(negedge CLK);
    frame(8'h72, 0, 0);
    chk("post_rst_reg", 32'(TECLADO_REG), 32'h72);
    chk("post_rst_ant", 32'(TECLADO_REG_ANTERIOR), 32'h00);

    // Random frames, including typematic repeats and bad frames
    prev = 8'h72;
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(9));
      b = (r < 2) ? prev : 8'($urandom_range(255));
      frame(b, r == 8, r == 9);
      prev = b;
    end

    // Drain and final state
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_reg", 32'(TECLADO_REG), 32'(m_reg));
    chk("final_ant", 32'(TECLADO_REG_ANTERIOR), 32'(m_ant));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
